jtag_arbiter: RTL and testbench

JTAG_ARBITER -- requirements
Module: jtag_arbiter

---
 rtl/jtag_arbiter_if.sv | 31 +++
 rtl/jtag_arbiter.sv | 146 ++++++++++++++
 tb/tb_jtag_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_arbiter_if.sv
// Requester / engine signal bundle for jtag_arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface jtag_arbiter_if #(
    parameter int LEN_W = 16
);
    logic             req_a;
    logic             req_b;
    logic             op_a;
    logic             op_b;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic             grant_a;
    logic             grant_b;
    logic             done_a;
    logic             done_b;
    logic             err;
    logic             work;
    logic             op;
    logic [LEN_W-1:0] len;
    logic             busy;

    modport slave (
        input  req_a, req_b, op_a, op_b, len_a, len_b, busy,
        output grant_a, grant_b, done_a, done_b, err, work, op, len
    );

    modport master (
        output req_a, req_b, op_a, op_b, len_a, len_b, busy,
        input  grant_a, grant_b, done_a, done_b, err, work, op, len
    );
endinterface

// File: rtl/jtag_arbiter.sv
// Round-robin arbiter sharing one JTAG engine between requesters A and B.
// Define JTAG_ARB_TIMEOUT_EN to bound the WAIT_BUSY dwell to TIMEOUT_CYCLES.
module jtag_arbiter #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    jtag_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e           state_q, state_d;
    sel_e             owner_q, owner_d;
    sel_e             last_q,  last_d;
    logic             op_q,    op_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             err_q,   err_d;
    logic             timeout;
    logic             pick_b;

`ifdef JTAG_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts completed WAIT_BUSY cycles; clears whenever the FSM leaves WAIT_BUSY.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT_BUSY && !bus.busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= SEL_A;
            last_q  <= SEL_B;
            op_q    <= 1'b0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // A wins unless B is the only requester or A was served last.
    assign pick_b = bus.req_b && (!bus.req_a || last_q == SEL_A);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        op_d    = op_q;
        len_d   = len_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.busy && (bus.req_a || bus.req_b)) begin
                    owner_d = pick_b ? SEL_B : SEL_A;
                    op_d    = pick_b ? bus.op_b  : bus.op_a;
                    len_d   = pick_b ? bus.len_b : bus.len_a;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (len_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.busy) begin
                    state_d = S_RUN;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (!bus.busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic active;
        active      = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
        bus.grant_a = active && (owner_q == SEL_A);
        bus.grant_b = active && (owner_q == SEL_B);
        bus.done_a  = (state_q == S_DONE) && (owner_q == SEL_A);
        bus.done_b  = (state_q == S_DONE) && (owner_q == SEL_B);
        bus.err     = (state_q == S_DONE) && err_q;
        bus.work    = (state_q == S_ISSUE) && (len_q != '0);
        bus.op      = op_q;
        bus.len     = len_q;
    end

endmodule

// File: tb/tb_jtag_arbiter.sv
// Directed bench for jtag_arbiter: a cycle table for arbitration and latching,
// plus hand sequences for the long engine run, mid-run reset and WAIT_BUSY dwell.
module tb_jtag_arbiter;

    logic clk;
    logic rst;

    jtag_arbiter_if #(.LEN_W(16)) bus ();

    jtag_arbiter #(
        .LEN_W         (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ra, rb, oa, ob;
        logic [15:0] la, lb;
        logic        bz;
    } in_t;

    typedef struct packed {
        logic        ga, gb, da, db, er, wk, op;
        logic [15:0] ln;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic out_t cur();
        out_t o;
        o = {bus.grant_a, bus.grant_b, bus.done_a, bus.done_b, bus.err, bus.work, bus.op, bus.len};
        return o;
    endfunction

    // r = {ra,rb,oa,ob}; f = {grant_a,grant_b,done_a,done_b,err,work,op}
    function automatic vec_t mk(input logic [3:0] r, input logic [15:0] la, input logic [15:0] lb,
                                input logic bz, input logic [6:0] f, input logic [15:0] ln);
        vec_t v;
        v.i = {r, la, lb, bz};
        v.o = {f, ln};
        return v;
    endfunction

    task automatic drive(input in_t v);
        bus.req_a = v.ra;
        bus.req_b = v.rb;
        bus.op_a  = v.oa;
        bus.op_b  = v.ob;
        bus.len_a = v.la;
        bus.len_b = v.lb;
        bus.busy  = v.bz;
    endtask

    // Checks the current sample first, then advances one cycle at a time.
    task automatic wait_sig(input int sel, input string name);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            case (sel)
                0:       hit = bus.work;
                1:       hit = bus.grant_b;
                2:       hit = bus.done_a;
                default: hit = bus.done_b;
            endcase
            if (!hit) begin
                @(negedge clk);
                #1;
            end
        end
        check(name, 32'(hit), 32'd1);
    endtask

    vec_t vecs [28];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_work, n_done, n_err, bcnt, hold_bad;
        logic        seen_op;
        logic [15:0] seen_len;

        clk = 1'b0;
        rst = 1'b0;
        drive('0);
        #3;
        check("reset_outputs", 32'(cur()), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        vecs[0]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0000000, 16'd0);
        vecs[1]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b1000011, 16'd3);
        vecs[2]  = mk(4'b1110, 16'd3, 16'd7, 1'b1, 7'b1000001, 16'd3);
        vecs[3]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b1000001, 16'd3);
        vecs[4]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0010001, 16'd3);
        vecs[5]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0000001, 16'd3);
        vecs[6]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0100010, 16'd7);
        vecs[7]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0100000, 16'd7);
        vecs[8]  = mk(4'b1110, 16'd3, 16'd7, 1'b1, 7'b0100000, 16'd7);
        vecs[9]  = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0100000, 16'd7);
        vecs[10] = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0001000, 16'd7);
        vecs[11] = mk(4'b1110, 16'd3, 16'd7, 1'b0, 7'b0000000, 16'd7);
        vecs[12] = mk(4'b0010, 16'd5, 16'd7, 1'b0, 7'b1000011, 16'd3);
        vecs[13] = mk(4'b0010, 16'd5, 16'd7, 1'b1, 7'b1000001, 16'd3);
        vecs[14] = mk(4'b0010, 16'd5, 16'd7, 1'b1, 7'b1000001, 16'd3);
        vecs[15] = mk(4'b0010, 16'd5, 16'd7, 1'b0, 7'b1000001, 16'd3);
        vecs[16] = mk(4'b0010, 16'd5, 16'd7, 1'b0, 7'b0010001, 16'd3);
        vecs[17] = mk(4'b1000, 16'd5, 16'd7, 1'b1, 7'b0000001, 16'd3);
        vecs[18] = mk(4'b1000, 16'd5, 16'd7, 1'b1, 7'b0000001, 16'd3);
        vecs[19] = mk(4'b1000, 16'd5, 16'd7, 1'b0, 7'b0000001, 16'd3);
        vecs[20] = mk(4'b1000, 16'd5, 16'd7, 1'b0, 7'b1000010, 16'd5);
        vecs[21] = mk(4'b1000, 16'd5, 16'd7, 1'b1, 7'b1000000, 16'd5);
        vecs[22] = mk(4'b1000, 16'd5, 16'd7, 1'b0, 7'b1000000, 16'd5);
        vecs[23] = mk(4'b0101, 16'd5, 16'd0, 1'b0, 7'b0010000, 16'd5);
        vecs[24] = mk(4'b0101, 16'd5, 16'd0, 1'b0, 7'b0000000, 16'd5);
        vecs[25] = mk(4'b0101, 16'd5, 16'd0, 1'b0, 7'b0100001, 16'd0);
        vecs[26] = mk(4'b0001, 16'd5, 16'd0, 1'b0, 7'b0001101, 16'd0);
        vecs[27] = mk(4'b0001, 16'd5, 16'd0, 1'b0, 7'b0000001, 16'd0);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(vecs[i].i);
            #1;
            check($sformatf("row%0d", i), 32'(cur()), 32'(vecs[i].o));
        end

        // Long engine run: busy rises one cycle after work and stays for 40 cycles.
        @(negedge clk);
        drive('0);
        bus.req_a = 1'b1;
        bus.op_a  = 1'b0;
        bus.len_a = 16'd10;
        n_work = 0; n_done = 0; n_err = 0; bcnt = 0;
        seen_op = 1'b1; seen_len = '0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            #1;
            if (bus.work) begin
                n_work++;
                seen_op  = bus.op;
                seen_len = bus.len;
            end
            if (bus.done_a) begin
                n_done++;
                bus.req_a = 1'b0;
            end
            if (bus.err) n_err++;
            if (bcnt > 0) begin
                bus.busy = 1'b1;
                bcnt--;
            end else begin
                bus.busy = 1'b0;
            end
            if (bus.work) bcnt = 40;
        end
        check("long_work_count", 32'(n_work), 32'd1);
        check("long_op", 32'(seen_op), 32'd0);
        check("long_len", 32'(seen_len), 32'd10);
        check("long_done_count", 32'(n_done), 32'd1);
        check("long_err_count", 32'(n_err), 32'd0);

        // Reset during RUN abandons B's transaction; B is served again afterwards.
        @(negedge clk);
        drive('0);
        bus.req_b = 1'b1;
        bus.op_b  = 1'b1;
        bus.len_b = 16'd9;
        #1;
        wait_sig(0, "rst_seq_work");
        bus.busy = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rst_seq_in_run", 32'(bus.grant_b), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_run", 32'(cur()), 32'd0);
        @(negedge clk);
        bus.busy = 1'b0;
        check("reset_held_no_done", 32'(bus.done_b), 32'd0);
        #1;
        rst = 1'b1;
        wait_sig(1, "post_reset_grant_b");
        check("post_reset_op_len", {15'd0, bus.op, bus.len}, {15'd0, 1'b1, 16'd9});
        check("post_reset_work", 32'(bus.work), 32'd1);
        bus.busy = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        bus.busy = 1'b0;
        wait_sig(3, "post_reset_done_b");
        bus.req_b = 1'b0;

        // WAIT_BUSY dwell with an engine that never raises busy.
        @(negedge clk);
        drive('0);
        bus.req_a = 1'b1;
        bus.op_a  = 1'b1;
        bus.len_a = 16'd4;
        #1;
        wait_sig(0, "dwell_work");
        hold_bad = 0;
`ifdef JTAG_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (bus.done_a || !bus.grant_a) hold_bad++;
        end
        check("timeout_not_early", 32'(hold_bad), 32'd0);
        @(negedge clk); #1;
        check("timeout_done_err", {30'd0, bus.done_a, bus.err}, 32'd3);
        bus.req_a = 1'b0;
        @(negedge clk); #1;
        check("timeout_back_idle", {29'd0, bus.grant_a, bus.work, bus.done_a}, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (bus.done_a || !bus.grant_a) hold_bad++;
        end
        check("wait_busy_hold", 32'(hold_bad), 32'd0);
        bus.busy = 1'b1;
        @(negedge clk); #1;
        bus.busy = 1'b0;
        wait_sig(2, "dwell_done_a");
        check("dwell_no_err", 32'(bus.err), 32'd0);
        bus.req_a = 1'b0;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
